// File: rtl/fib_req_arbiter.sv
// -----------------------------------------------------------------------------
// fib_req_arbiter
//
// Round-robin arbiter in front of an iterative Fibonacci engine. Up to NUM_REQ
// requesters each present an index n; the arbiter grants one of them in IDLE,
// computes F(n) one step per clock in COMPUTE, then holds the result in RESP
// until the consumer takes it. Only one job is in flight at a time.
//
// Parameters
//   DATA_WIDTH  width of the Fibonacci result
//   NUM_REQ     number of requesters (>= 2)
//   IDX_WIDTH   width of the requested index n
//
// Ports
//   clk         clock, rising edge
//   resetn      synchronous active-low reset
//   req_valid   [NUM_REQ]            per-requester request valid
//   req_index   [NUM_REQ*IDX_WIDTH]  per-requester n, requester i at [i*IDX_WIDTH +: IDX_WIDTH]
//   req_ready   [NUM_REQ]            accept strobe, one-hot or zero
//   resp_valid                       result available
//   resp_ready                       consumer accepts result
//   resp_data   [DATA_WIDTH]         F(n)
//   resp_id     [$clog2(NUM_REQ)]    requester owning resp_data
//   busy                             high whenever not IDLE
//
// Build option
//   FIB_SAT_EN  when defined, a job whose result overflows DATA_WIDTH returns
//               all-ones instead of the wrapped value.
// -----------------------------------------------------------------------------
module fib_req_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  parameter  int IDX_WIDTH  = 6,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*IDX_WIDTH-1:0] req_index,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic [ID_WIDTH-1:0]          resp_id,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESP
  } state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] cur;
  logic [IDX_WIDTH-1:0]  cnt;

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [IDX_WIDTH-1:0]  grant_n;
  logic                  accept;
  logic [ID_WIDTH-1:0]   next_ptr;

`ifdef FIB_SAT_EN
  logic                  ovf;
  logic [DATA_WIDTH:0]   sum;
  assign sum = {1'b0, prev} + {1'b0, cur};
`else
  logic [DATA_WIDTH-1:0] sum;
  assign sum = prev + cur;
`endif

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(j);
      end
    end
    // Strobe is suppressed while reset is asserted so nothing looks accepted.
    if (state == IDLE && resetn && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept   = |req_ready;
  assign grant_n  = req_index[grant_idx*IDX_WIDTH +: IDX_WIDTH];
  assign next_ptr = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      prev       <= '0;
      cur        <= DATA_WIDTH'(1);
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      busy       <= 1'b0;
`ifdef FIB_SAT_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_id <= grant_idx;
            prev    <= '0;
            cur     <= DATA_WIDTH'(1);
            cnt     <= grant_n;
            rr_ptr  <= next_ptr;
            busy    <= 1'b1;
`ifdef FIB_SAT_EN
            ovf     <= 1'b0;
`endif
            if (grant_n != '0) begin
              state <= COMPUTE;
            end else begin
              // F(0) is ready immediately.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= '0;
            end
          end
        end

        COMPUTE: begin
          prev <= cur;
          cur  <= sum[DATA_WIDTH-1:0];
          cnt  <= cnt - 1'b1;
`ifdef FIB_SAT_EN
          // The sum formed on the last step is F(n+1), which is never
          // returned, so it must not mark the job as overflowed.
          if (sum[DATA_WIDTH] && cnt != IDX_WIDTH'(1)) begin
            ovf <= 1'b1;
          end
`endif
          if (cnt == IDX_WIDTH'(1)) begin
            // prev takes cur on this edge, so cur is the final result.
            state      <= RESP;
            resp_valid <= 1'b1;
`ifdef FIB_SAT_EN
            resp_data  <= ovf ? '1 : cur;
`else
            resp_data  <= cur;
`endif
          end
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fib_req_arbiter
//
// Directed bench for fib_req_arbiter. Two instances share clock and reset:
// dut (default 32-bit result) and dut8 (8-bit result, for wrap/saturate).
// Inputs are driven 1 ns after the rising edge and outputs sampled 1-2 ns
// after it, away from the active edge.
// -----------------------------------------------------------------------------
module tb_fib_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;

  logic [3:0]  req_valid;
  logic [23:0] req_index;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_id;
  logic        busy;

  logic [3:0]  req_valid8;
  logic [23:0] req_index8;
  logic [3:0]  req_ready8;
  logic        resp_valid8;
  logic [7:0]  resp_data8;
  logic [1:0]  resp_id8;
  logic        busy8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fib_req_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .IDX_WIDTH(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_index  (req_index),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  fib_req_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .IDX_WIDTH(6)) dut8 (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid8),
    .req_index  (req_index8),
    .req_ready  (req_ready8),
    .resp_valid (resp_valid8),
    .resp_ready (resp_ready),
    .resp_data  (resp_data8),
    .resp_id    (resp_id8),
    .busy       (busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one job on the chosen instance (sel=1 -> dut8) with resp_ready high
  // and reports what was observed; callers compare against expectations.
  task automatic run_job(input bit sel, input int id, input int n,
                         output bit granted, output int lat,
                         output logic [31:0] data, output logic [1:0] rid);
    if (sel) begin
      req_valid8[id]         = 1'b1;
      req_index8[id*6 +: 6]  = 6'(n);
    end else begin
      req_valid[id]          = 1'b1;
      req_index[id*6 +: 6]   = 6'(n);
    end
    #1;
    granted = sel ? req_ready8[id] : req_ready[id];
    tick();  // accept edge
    if (sel) req_valid8[id] = 1'b0;
    else     req_valid[id]  = 1'b0;
    lat = 0;
    while (!(sel ? resp_valid8 : resp_valid) && lat < 100) begin
      tick();
      lat++;
    end
    data = sel ? 32'(resp_data8) : resp_data;
    rid  = sel ? resp_id8 : resp_id;
    tick();  // response handshake edge
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '0;
    req_index  = '0;
    req_valid8 = '0;
    req_index8 = '0;
    tick();
    tick();
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if ({resp_valid, busy, resp_id, resp_data} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b busy=%b id=%0d data=%0d exp all zero",
               resp_valid, busy, resp_id, resp_data);
    end
  endtask

  task automatic test_round_robin();
    int exp_data [4] = '{2, 3, 5, 8};
    int w;
    req_index = {6'd6, 6'd5, 6'd4, 6'd3};
    req_valid = 4'hF;
    resetn    = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      w = 0;
      while (req_ready == 4'b0000 && w < 50) begin
        tick();
        #1;
        w++;
      end
      checks++;
      if (req_ready !== 4'(1 << (j % 4))) begin
        failures++;
        $display("FAIL rr_grant job=%0d got=%b exp=%b", j, req_ready, 4'(1 << (j % 4)));
      end
      tick();  // accept edge
      w = 0;
      while (!resp_valid && w < 50) begin
        tick();
        w++;
      end
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(j % 4) || resp_data !== 32'(exp_data[j % 4])
          || w != 3 + (j % 4)) begin
        failures++;
        $display("FAIL rr_resp job=%0d got valid=%b id=%0d data=%0d lat=%0d exp id=%0d data=%0d lat=%0d",
                 j, resp_valid, resp_id, resp_data, w, j % 4, exp_data[j % 4], 3 + (j % 4));
      end
      if (j == 7) req_valid = '0;
      #1;
    end
    tick();  // final handshake
  endtask

  task automatic test_basic();
    bit g;
    int lat;
    logic [31:0] d;
    logic [1:0] id;
    int ns   [3] = '{10, 0, 1};
    int expd [3] = '{55, 0, 1};
    for (int t = 0; t < 3; t++) begin
      run_job(1'b0, 0, ns[t], g, lat, d, id);
      checks++;
      if (!g || lat != ns[t] || d !== 32'(expd[t]) || id !== 2'd0) begin
        failures++;
        $display("FAIL basic_n%0d got grant=%b lat=%0d data=%0d id=%0d exp grant=1 lat=%0d data=%0d id=0",
                 ns[t], g, lat, d, id, ns[t], expd[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    req_valid            = 4'b0100;
    req_index[2*6 +: 6]  = 6'd7;
    resp_ready           = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=0100", req_ready);
    end
    tick();  // accept edge
    req_valid = 4'b1011;
    req_index[0 +: 6] = 6'd1;
    req_index[6 +: 6] = 6'd1;
    req_index[18 +: 6] = 6'd1;
    w = 0;
    while (!resp_valid && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (w != 7) begin
      failures++;
      $display("FAIL bp_latency got=%0d exp=7", w);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'd13 || resp_id !== 2'd2
          || req_ready !== 4'b0000 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%0d id=%0d ready=%b busy=%b exp 1/13/2/0000/1",
                 k, resp_valid, resp_data, resp_id, req_ready, busy);
      end
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();  // handshake
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got valid=%b busy=%b exp 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_width8();
    bit g;
    int lat;
    logic [31:0] d;
    logic [1:0] id;
    int ns   [3] = '{13, 14, 5};
`ifdef FIB_SAT_EN
    int expd [3] = '{233, 255, 5};
`else
    int expd [3] = '{233, 121, 5};
`endif
    for (int t = 0; t < 3; t++) begin
      run_job(1'b1, 1, ns[t], g, lat, d, id);
      checks++;
      if (!g || lat != ns[t] || d !== 32'(expd[t]) || id !== 2'd1) begin
        failures++;
        $display("FAIL w8_n%0d got grant=%b lat=%0d data=%0d id=%0d exp grant=1 lat=%0d data=%0d id=1",
                 ns[t], g, lat, d, id, ns[t], expd[t]);
      end
    end
  endtask

  task automatic test_reset_abort();
    req_valid           = 4'b0010;
    req_index[6 +: 6]   = 6'd20;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL abort_grant got=%b exp=0010", req_ready);
    end
    tick();  // accept edge, COMPUTE cycle 1 follows
    req_valid = '0;
    for (int k = 0; k < 5; k++) tick();  // now in COMPUTE cycle 6
    resetn    = 1'b0;
    req_valid = 4'b0011;
    tick();  // reset edge
    checks++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0 || resp_data !== 32'd0
        || resp_id !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs got ready=%b valid=%b data=%0d id=%0d busy=%b exp all zero",
               req_ready, resp_valid, resp_data, resp_id, busy);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL abort_rr_restart got=%b exp=0001", req_ready);
    end
    req_valid = '0;
    for (int k = 0; k < 25; k++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_resp cycle=%0d got valid=%b busy=%b exp 0/0", k, resp_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_backpressure();
    test_width8();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fib_req_arbiter.md
FIB_REQ_ARBITER -- requirements
Module: fib_req_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of Fibonacci result.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, at least 2.
REQ-003 Parameter IDX_WIDTH, default 6: width of the requested Fibonacci index n.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_index  input  NUM_REQ*IDX_WIDTH  per-requester index n; requester i occupies bits [i*IDX_WIDTH +: IDX_WIDTH].
REQ-008 req_ready  output  NUM_REQ  per-requester accept strobe, one-hot or zero.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_data  output  DATA_WIDTH  F(n), with F(0)=0 and F(1)=1.
REQ-012 resp_id  output  $clog2(NUM_REQ)  index of the requester that owns resp_data.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, COMPUTE and RESP, one job in flight at a time.
REQ-015 IDLE: grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ; req_ready[i]=1 combinationally for that i only; accept = req_valid[i] & req_ready[i].
REQ-016 req_ready SHALL be all-zero in COMPUTE and RESP, and in IDLE when no req_valid is set.
REQ-017 On accept: latch n and id; set prev=0, cur=1, cnt=n; set rr_ptr = (i+1) mod NUM_REQ; go to COMPUTE if n>0, otherwise go to RESP.
REQ-018 COMPUTE, per cycle: prev<=cur; cur<=prev+cur (truncated to DATA_WIDTH); cnt<=cnt-1; go to RESP when cnt==1.
REQ-019 Latency: resp_valid SHALL rise exactly n clock edges after the accept edge (n=0: the cycle immediately after the accept edge).
REQ-020 RESP: resp_valid=1, resp_data=prev, resp_id=latched id; all three SHALL stay stable until resp_valid & resp_ready.
REQ-021 On the RESP handshake, go to IDLE; no accept in that same cycle, so back-to-back jobs SHALL be separated by at least one IDLE cycle.
REQ-022 Requests arriving while busy SHALL wait; requesters keep req_valid and req_index stable until accepted.
REQ-023 Round-robin: with all requesters continuously valid, each SHALL be served once per NUM_REQ jobs.

Reset
REQ-024 resetn=0 at a clock edge SHALL force: state=IDLE, rr_ptr=0, prev=0, cur=1, cnt=0, resp_valid=0, resp_data=0, resp_id=0, busy=0, any overflow flag=0.
REQ-025 Reset in COMPUTE or RESP SHALL abort the job without producing a response; req_ready SHALL be 0 while resetn=0.

Configuration
REQ-026 Macro FIB_SAT_EN: when defined, a sticky overflow flag SHALL be set the first time prev+cur exceeds 2^DATA_WIDTH-1 in COMPUTE, and resp_data SHALL be all-ones for that job; the flag SHALL clear on the next accept.
REQ-027 Without FIB_SAT_EN, arithmetic SHALL wrap modulo 2^DATA_WIDTH and no overflow logic SHALL exist.

Verification
REQ-028 Requester 0 sends n=10 with resp_ready=1 -> resp_data=55, resp_id=0, resp_valid 10 edges after accept; n=0 -> 0 after 0 edges; n=1 -> 1.
REQ-029 All 4 requesters valid from reset, with distinct n=3,4,5,6 -> grants in order 0,1,2,3 and responses 2,3,5,8; a repeat round starts again at 0.
REQ-030 Requester 2 sends n=7, resp_ready held low for 5 cycles -> resp_valid=1, resp_data=13 and resp_id=2 stable for all 5 cycles; req_ready stays 0 for the other requesters.
REQ-031 DATA_WIDTH=8: n=13 -> 233; n=14 -> 121 without FIB_SAT_EN, 255 with FIB_SAT_EN; the following job with n=5 -> 5.
REQ-032 Requester 1 sends n=20, resetn pulsed low during cycle 6 of COMPUTE -> no response; all outputs at reset values; next grant searches from requester 0.
